// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle ALU with add/sub, bitwise logic and serial
// shift/rotate behind a valid/ready handshake on both sides.
// One operation is in flight at a time. A shift by N takes N clocks from the
// accept edge. The first step is applied on the accept edge itself, so a
// shift by 1 completes exactly like a single-cycle op.
module alu_seq_unit #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [SHW-1:0]   shamt,
    input  logic             ser_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             zero,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_out_q, c_out_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       sop_q, sop_d;      // latched shift/rotate kind
    logic [SHW-1:0]   cnt_q, cnt_d;      // steps still to apply

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   step_a;            // {bit out, shifted value} from operand a
    logic [WIDTH:0]   step_w;            // {bit out, shifted value} from work value

    // One shift/rotate step: returns {bit shifted out, new value}.
    function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] r,
                                                  input logic [1:0]       sop,
                                                  input logic             fill);
        logic [WIDTH:0] res;
        case (sop)
            2'b00:   res = {r[WIDTH-1], r[WIDTH-2:0], fill};       // SHL
            2'b01:   res = {r[0], fill, r[WIDTH-1:1]};             // SHR
            2'b10:   res = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]}; // ROL
            default: res = {r[0], r[0], r[WIDTH-1:1]};             // ROR
        endcase
        return res;
    endfunction

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign c_out     = c_out_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

    // Next-state and datapath: compute on accept, step while shifting, hold in DONE.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        sop_d    = sop_q;
        cnt_d    = cnt_q;
        bx       = '0;
        sum      = '0;
        step_a   = shift_step(a, op[1:0], ser_in);
        step_w   = shift_step(result_q, sop_q, ser_in);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (op[3:2])
                        2'b00: begin
                            case (op[1:0])
                                2'b00:   bx = b;
                                2'b01:   bx = ~b;
                                2'b10:   bx = '0;
                                default: bx = '1;
                            endcase
                            sum      = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, c_in};
                            result_d = sum[WIDTH-1:0];
                            c_out_d  = sum[WIDTH];
                            ovf_d    = (a[WIDTH-1] == bx[WIDTH-1]) &&
                                       (sum[WIDTH-1] != a[WIDTH-1]);
                            zero_d   = (sum[WIDTH-1:0] == '0);
                            state_d  = S_DONE;
                        end
                        2'b01: begin
                            case (op[1:0])
                                2'b00:   result_d = a & b;
                                2'b01:   result_d = a | b;
                                2'b10:   result_d = a ^ b;
                                default: result_d = ~a;
                            endcase
                            c_out_d = 1'b0;
                            ovf_d   = 1'b0;
                            zero_d  = (result_d == '0);
                            state_d = S_DONE;
                        end
                        2'b10: begin
                            sop_d = op[1:0];
                            ovf_d = 1'b0;
                            if (shamt == '0) begin
                                result_d = a;
                                c_out_d  = 1'b0;
                                zero_d   = (a == '0);
                                state_d  = S_DONE;
                            end else begin
                                // First step happens on the accept edge.
                                result_d = step_a[WIDTH-1:0];
                                c_out_d  = step_a[WIDTH];
                                zero_d   = (step_a[WIDTH-1:0] == '0);
                                cnt_d    = shamt - SHW'(1);
                                state_d  = (shamt == SHW'(1)) ? S_DONE : S_SHIFT;
                            end
                        end
                        default: begin
                            result_d = '0;
                            c_out_d  = 1'b0;
                            ovf_d    = 1'b0;
                            zero_d   = 1'b1;
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                result_d = step_w[WIDTH-1:0];
                c_out_d  = step_w[WIDTH];
                zero_d   = (step_w[WIDTH-1:0] == '0);
                cnt_d    = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset discards any pending operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            c_out_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            sop_q    <= 2'b00;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            sop_q    <= sop_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit (WIDTH=8): table of operations with
// hand-computed results, plus sequences for backpressure, live serial fill
// and reset in the middle of a shift.
module tb_alu_seq_unit;

    localparam int W   = 8;
    localparam int SHW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           c_in;
    logic [SHW-1:0] shamt;
    logic           ser_in;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   result;
    logic           c_out;
    logic           zero;
    logic           ovf;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(W), .SHW(SHW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .c_in(c_in), .shamt(shamt), .ser_in(ser_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .c_out(c_out), .zero(zero), .ovf(ovf)
    );

    typedef struct {
        logic [3:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           cin;
        logic [SHW-1:0] sh;
        logic           ser;
        logic [W-1:0]   r;
        logic           c;
        logic           z;
        logic           v;
        int             lat;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [3:0] op_i, input logic [7:0] a_i,
                                input logic [7:0] b_i, input logic cin_i,
                                input logic [3:0] sh_i, input logic ser_i,
                                input logic [7:0] r_i, input logic c_i,
                                input logic z_i, input logic v_i, input int lat_i);
        vec_t v;
        v.op = op_i; v.a = a_i; v.b = b_i; v.cin = cin_i; v.sh = sh_i; v.ser = ser_i;
        v.r = r_i; v.c = c_i; v.z = z_i; v.v = v_i; v.lat = lat_i;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one op, scramble the operands, wait for the result, then drain it.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        bit busy_ok;
        op = v.op; a = v.a; b = v.b; c_in = v.cin; shamt = v.sh; ser_in = v.ser;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        check($sformatf("%s in_ready_before", tag), {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        a = ~a; b = ~b; c_in = ~c_in; shamt = ~shamt; op = op ^ 4'h5;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (in_ready) busy_ok = 1'b0;
        check($sformatf("%s latency", tag), lat, v.lat);
        check($sformatf("%s in_ready_busy", tag), {31'd0, busy_ok}, 32'd1);
        check($sformatf("%s result", tag), {24'd0, result}, {24'd0, v.r});
        check($sformatf("%s c_out", tag), {31'd0, c_out}, {31'd0, v.c});
        check($sformatf("%s zero", tag), {31'd0, zero}, {31'd0, v.z});
        check($sformatf("%s ovf", tag), {31'd0, ovf}, {31'd0, v.v});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check($sformatf("%s back_to_idle", tag), {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        //          op     a      b      cin   sh     ser   res    c     z     v    lat
        vt.push_back(mk(4'h0, 8'hF0, 8'h20, 1'b0, 4'd0,  1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1));
        vt.push_back(mk(4'h1, 8'h80, 8'h01, 1'b1, 4'd0,  1'b0, 8'h7F, 1'b1, 1'b0, 1'b1, 1));
        vt.push_back(mk(4'h0, 8'hFF, 8'h01, 1'b0, 4'd0,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1));
        vt.push_back(mk(4'h0, 8'h7F, 8'h01, 1'b0, 4'd0,  1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1));
        vt.push_back(mk(4'h1, 8'h05, 8'h05, 1'b1, 4'd0,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1));
        vt.push_back(mk(4'h2, 8'hFF, 8'h33, 1'b1, 4'd0,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1));
        vt.push_back(mk(4'h3, 8'h00, 8'h33, 1'b0, 4'd0,  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1));
        vt.push_back(mk(4'h3, 8'h80, 8'h00, 1'b0, 4'd0,  1'b0, 8'h7F, 1'b1, 1'b0, 1'b1, 1));
        vt.push_back(mk(4'h4, 8'h3C, 8'h0F, 1'b1, 4'd0,  1'b0, 8'h0C, 1'b0, 1'b0, 1'b0, 1));
        vt.push_back(mk(4'h5, 8'hF0, 8'h0F, 1'b0, 4'd0,  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1));
        vt.push_back(mk(4'h6, 8'hAA, 8'hAA, 1'b0, 4'd0,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1));
        vt.push_back(mk(4'h7, 8'h0F, 8'hFF, 1'b0, 4'd0,  1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1));
        vt.push_back(mk(4'h1, 8'h80, 8'h01, 1'b1, 4'd0,  1'b0, 8'h7F, 1'b1, 1'b0, 1'b1, 1));
        vt.push_back(mk(4'h8, 8'h81, 8'h00, 1'b0, 4'd3,  1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 3));
        vt.push_back(mk(4'h9, 8'h81, 8'h00, 1'b0, 4'd2,  1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 2));
        vt.push_back(mk(4'hB, 8'h01, 8'h00, 1'b0, 4'd1,  1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1));
        vt.push_back(mk(4'hA, 8'hA5, 8'h00, 1'b0, 4'd0,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1));
        vt.push_back(mk(4'hA, 8'h81, 8'h00, 1'b0, 4'd9,  1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 9));
        vt.push_back(mk(4'h9, 8'h01, 8'h00, 1'b0, 4'd10, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 10));
        vt.push_back(mk(4'h8, 8'h80, 8'h00, 1'b0, 4'd1,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1));
        vt.push_back(mk(4'hC, 8'hFF, 8'hFF, 1'b1, 4'd3,  1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1));
        vt.push_back(mk(4'hF, 8'h12, 8'h34, 1'b1, 4'd0,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1));
        vt.push_back(mk(4'hA, 8'h00, 8'h00, 1'b0, 4'd0,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1));

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'h0; a = '0; b = '0; c_in = 1'b0; shamt = '0; ser_in = 1'b0;
        #12;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset result", {24'd0, result}, 32'd0);
        check("reset flags", {29'd0, c_out, zero, ovf}, 32'd0);
        #10 rst_n = 1'b1;
        tick();

        for (int i = 0; i < vt.size(); i++) begin
            run_op(vt[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held, no new accept while DONE.
        op = 4'h0; a = 8'hF0; b = 8'h20; c_in = 1'b0; shamt = '0; in_valid = 1'b1;
        tick();
        op = 4'h6; a = 8'h55; b = 8'h00;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d out_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d in_ready", k), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp%0d result", k), {24'd0, result}, 32'h10);
            check($sformatf("bp%0d flags", k), {29'd0, c_out, zero, ovf}, 32'b100);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release idle", {30'd0, out_valid, in_ready}, 32'd1);

        // Serial fill bit is sampled live on every step: SHL 00 by 3 with fill 1,0,1.
        op = 4'h8; a = 8'h00; shamt = 4'd3; ser_in = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; ser_in = 1'b0;
        tick();
        ser_in = 1'b1;
        tick();
        check("live ser out_valid", {31'd0, out_valid}, 32'd1);
        check("live ser result", {24'd0, result}, 32'h05);
        check("live ser c_out", {31'd0, c_out}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during the second SHIFT cycle of SHR by 5.
        op = 4'h9; a = 8'hFF; shamt = 4'd5; ser_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid busy", {30'd0, out_valid, in_ready}, 32'd0);
        check("mid partial", {24'd0, result}, 32'h3F);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        check("mid rst in_ready", {31'd0, in_ready}, 32'd1);
        check("mid rst result", {24'd0, result}, 32'd0);
        check("mid rst c_out", {31'd0, c_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(mk(4'h4, 8'h3C, 8'h0F, 1'b0, 4'd0, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0, 1), "post_rst_and");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard stop in case the sequence above stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
